regfile_mp: RTL

- Parametrised multi-port integer register file, successor to the single-write 2-read file in the decode stage.
- Adds configurable width, depth and port counts, plus same-cycle write-to-read bypass with deterministic multi-writer priority.
- Adds a per-register busy scoreboard for issue logic, and a post-reset clearing sweep that loads architectural init values.

---
 rtl/regfile_mp.sv | 122 ++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write bypass, a per-register busy scoreboard,
// and a post-reset sweep that loads the architectural init values.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int SP_IDX   = 2,
  parameter int SP_INIT  = 2048,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  output logic              ready
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam logic [AW:0]     LAST_IDX = (AW+1)'(NREGS-1);
  localparam logic [AW:0]     SP_IDX_W = (AW+1)'(SP_IDX);
  localparam logic [XLEN-1:0] SP_VAL   = XLEN'(SP_INIT);

  state_t            state_q, state_d;
  logic [AW:0]       idx_q, idx_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [NWR-1:0]    wr_ok;
  logic              alloc_ok;

  assign ready = (state_q == ST_RUN);

  // Accepted writes/allocs: only in RUN, and never to a hardwired zero register.
  always_comb begin
    wr_ok = '0;
    for (int k = 0; k < NWR; k++) begin
      wr_ok[k] = ready && wr_en[k] &&
                 !((ZERO_REG != 0) && (wr_addr[k*AW +: AW] == '0));
    end
    alloc_ok = ready && alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    busy_d  = busy_q;
    case (state_q)
      ST_CLEAR: begin
        regs_d[idx_q[AW-1:0]] = (idx_q == SP_IDX_W) ? SP_VAL : '0;
        idx_d = idx_q + (AW+1)'(1);
        if (idx_q == LAST_IDX) state_d = ST_RUN;
      end
      default: begin
        // Ascending port order lets the highest-numbered writer win on an address clash.
        for (int k = 0; k < NWR; k++) begin
          if (wr_ok[k]) begin
            regs_d[wr_addr[k*AW +: AW]] = wr_data[k*XLEN +: XLEN];
            busy_d[wr_addr[k*AW +: AW]] = 1'b0;
          end
        end
        if (alloc_ok) busy_d[alloc_addr] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      regs_q  <= regs_d;
    end
  end

  logic [AW-1:0]   ra;
  logic [XLEN-1:0] val;
  logic            hit;
  logic            bz;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra  = '0;
    val = '0;
    hit = 1'b0;
    bz  = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      ra  = rd_addr[p*AW +: AW];
      val = regs_q[ra];
      hit = 1'b0;
      for (int k = 0; k < NWR; k++) begin
        if (wr_ok[k] && (wr_addr[k*AW +: AW] == ra)) begin
          hit = 1'b1;
          if (BYPASS != 0) val = wr_data[k*XLEN +: XLEN];
        end
      end
      if (!rd_en[p] || !ready || ((ZERO_REG != 0) && (ra == '0))) val = '0;
      bz = rd_en[p] && ready && busy_q[ra];
      // A retiring producer clears busy in-cycle unless a new producer claims it too.
      if ((BYPASS != 0) && hit && !(alloc_ok && (alloc_addr == ra))) bz = 1'b0;
      rd_data[p*XLEN +: XLEN] = val;
      rd_busy[p] = bz;
    end
  end

endmodule
